mem_uart_bridge: RTL and testbench
==================================

# mem_uart_bridge

Memory/UART bridge directly downstream of the CPU core: it consumes the core's instruction port (base) and data port (ext) and returns read data plus the fetch-valid flag. It maps addresses onto two external 32-bit SRAMs (BaseRAM, ExtRAM) and a UART with MMIO data/status registers. It resolves structural conflicts when a data access targets BaseRAM and stalls instruction fetch for that cycle.

## Interface
Parameters:
- CLK_FREQ, 50_000_000, core clock in Hz
- BAUD, 9600, UART bit rate; divisor DIV = CLK_FREQ/BAUD, computed at elaboration

Ports:
- clk  in  1  core clock, all state on rising edge
- rst  in  1  asynchronous, active-low reset
- cpu_base_addr_i  in  32  fetch byte address
- cpu_base_ce_i  in  1  fetch request
- cpu_base_rdata_o  out  32  fetch data, registered
- cpu_ext_addr_i  in  32  data byte address
- cpu_ext_wdata_i  in  32  store data
- cpu_ext_be_i  in  4  byte enables, active-high
- cpu_ext_ce_i / cpu_ext_oe_i / cpu_ext_we_i  in  1 each  data request / read / write
- cpu_ext_rdata_o  out  32  load data, registered
- to_if_valid_o  out  1  cpu_base_rdata_o holds valid fetch data this cycle
- base_ram_addr_o, ext_ram_addr_o  out  20  SRAM word addresses (addr[21:2])
- base_ram_wdata_o, ext_ram_wdata_o  out  32  SRAM write data
- base_ram_rdata_i, ext_ram_rdata_i  in  32  SRAM read data
- base_ram_be_n_o, ext_ram_be_n_o  out  4  byte enables, active-low
- base_ram_ce_n_o / oe_n_o / we_n_o, ext_ram_ce_n_o / oe_n_o / we_n_o  out  1 each  SRAM strobes, active-low
- base_ram_data_oe_o, ext_ram_data_oe_o  out  1  drive data bus (write cycle)
- uart_txd_o  out  1  serial out, idle high
- uart_rxd_i  in  1  serial in, asynchronous to clk

## Operation
- Decode (ext address): 0x8000_0000–0x803F_FFFF BaseRAM; 0x8040_0000–0x807F_FFFF ExtRAM; 0xBFD0_03F8 UART data; 0xBFD0_03FC UART status; all else unmapped (reads return 0, writes ignored).
- Fetch always targets BaseRAM.
- Conflict: ext request with ce=1 decoding to BaseRAM owns BaseRAM that cycle; fetch is not served; to_if_valid_o=0 in the following cycle. Core must re-present the fetch.
- SRAM write: we_n low one cycle, be_n = ~cpu_ext_be_i, data_oe=1; oe_n high. SRAM read: oe_n low, be_n=4'b0000.
- UART status read: bit0 = TX idle (write accepted), bit1 = RX byte available, bits[31:2]=0.
- UART data write: byte wdata[7:0] loaded to TX shifter if idle; if busy, write dropped. Frame 8N1, LSB first, each bit DIV cycles.
- UART data read: returns {24'b0, rx byte} and pops RX storage; empty read returns 0.
- RX: 2-flop synchronizer; start detected on falling edge; sample at DIV/2 then every DIV; stop bit must be 1 else frame discarded.

## Timing
- Read latency 1 cycle: request sampled at edge N, rdata valid after edge N+1 (SRAM strobes registered at N, rdata_i captured at N+1).
- Writes complete in 1 cycle; no back-pressure to ext port.
- Reset values: all *_ce_n/oe_n/we_n/be_n = 1, data_oe=0, addrs/wdata=0, rdata outputs 0, to_if_valid_o=0, uart_txd_o=1, TX/RX FSMs IDLE, RX storage empty.
- TX FSM: IDLE→START(DIV)→DATA×8(DIV each)→STOP(DIV)→IDLE; status bit0 low from load cycle until STOP ends.
- RX FSM: IDLE→START(verify low at DIV/2)→DATA×8→STOP→IDLE; false start (high at DIV/2) returns to IDLE.
- Simultaneous RX push and CPU pop same cycle: both happen, occupancy unchanged.
- Reset asserted mid-frame: TX line returns high immediately; partial RX frame discarded.

## Configuration
- UART_RX_FIFO_EN defined: 4-entry RX FIFO with wrapping 2-bit pointers and 3-bit count; byte arriving when full is dropped.
- Undefined: single holding register; new byte arriving while occupied is dropped; status bit1 = holding register occupied.

## Test plan
- Reset low 3 cycles then high -> txd=1, all SRAM strobes high, to_if_valid_o=0, status read = 0x1.
- Fetch 0x8000_0010 with base_ram_rdata_i=0x1234_5678 -> base_ram_addr_o=0x00004, next cycle rdata=0x1234_5678, to_if_valid_o=1.
- Store 0xDEAD_BEEF to 0x8040_0008 be=4'b0011 -> ext_ram_we_n_o low one cycle, be_n=4'b1100, addr=0x00002.
- Load 0x8000_0100 concurrent with fetch -> base RAM serves load, to_if_valid_o=0 next cycle, cpu_ext_rdata_o = SRAM data.
- Write 0x55 to 0xBFD0_03F8, DIV=4 -> txd low 4 cycles, then 1,0,1,0,1,0,1,0 each 4 cycles, stop high; status bit0=0 for 40 cycles.
- Drive frame 0xA3 on rxd -> status bit1=1; data read returns 0x0000_00A3, then bit1=0; with UART_RX_FIFO_EN, 5 frames unread -> first 4 retained, 5th dropped.

Source files
------------

// File: rtl/mem_uart_bridge.sv
// Memory/UART bridge: maps the core's fetch and data ports onto BaseRAM, ExtRAM and an 8N1 UART.
// Define UART_RX_FIFO_EN for a 4-entry RX FIFO; by default a single holding register is used.
module mem_uart_bridge #(
    parameter int unsigned CLK_FREQ = 50_000_000,
    parameter int unsigned BAUD     = 9600
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] cpu_base_addr_i,
    input  logic        cpu_base_ce_i,
    output logic [31:0] cpu_base_rdata_o,
    input  logic [31:0] cpu_ext_addr_i,
    input  logic [31:0] cpu_ext_wdata_i,
    input  logic [3:0]  cpu_ext_be_i,
    input  logic        cpu_ext_ce_i,
    input  logic        cpu_ext_oe_i,
    input  logic        cpu_ext_we_i,
    output logic [31:0] cpu_ext_rdata_o,
    output logic        to_if_valid_o,
    output logic [19:0] base_ram_addr_o,
    output logic [31:0] base_ram_wdata_o,
    input  logic [31:0] base_ram_rdata_i,
    output logic [3:0]  base_ram_be_n_o,
    output logic        base_ram_ce_n_o,
    output logic        base_ram_oe_n_o,
    output logic        base_ram_we_n_o,
    output logic        base_ram_data_oe_o,
    output logic [19:0] ext_ram_addr_o,
    output logic [31:0] ext_ram_wdata_o,
    input  logic [31:0] ext_ram_rdata_i,
    output logic [3:0]  ext_ram_be_n_o,
    output logic        ext_ram_ce_n_o,
    output logic        ext_ram_oe_n_o,
    output logic        ext_ram_we_n_o,
    output logic        ext_ram_data_oe_o,
    output logic        uart_txd_o,
    input  logic        uart_rxd_i
);

    localparam int unsigned DIV  = CLK_FREQ / BAUD;
    localparam int unsigned HALF = DIV / 2;
    localparam int unsigned CW   = $clog2(DIV) + 1;
    localparam logic [CW-1:0] DIV_M1  = CW'(DIV - 1);
    localparam logic [CW-1:0] HALF_M1 = CW'(HALF - 1);

    typedef enum logic [2:0] {SRC_NONE, SRC_BASE, SRC_EXT, SRC_UART, SRC_ZERO} src_t;
    typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // Address decode of the data port
    logic w_ext_base, w_ext_ext, w_uart_dat, w_uart_sta, w_ext_rd, w_ext_wr;
    assign w_ext_base = cpu_ext_ce_i && (cpu_ext_addr_i[31:22] == 10'h200);
    assign w_ext_ext  = cpu_ext_ce_i && (cpu_ext_addr_i[31:22] == 10'h201);
    assign w_uart_dat = (cpu_ext_addr_i == 32'hBFD0_03F8);
    assign w_uart_sta = (cpu_ext_addr_i == 32'hBFD0_03FC);
    assign w_ext_rd   = cpu_ext_ce_i && cpu_ext_oe_i && !cpu_ext_we_i;
    assign w_ext_wr   = cpu_ext_ce_i && cpu_ext_we_i;

    logic w_unused;
    assign w_unused = ^{cpu_base_addr_i[31:22], cpu_base_addr_i[1:0]};

    logic        w_tx_idle, w_tx_load, w_rx_avail, w_rx_pop, w_push_ok;
    logic [7:0]  w_rx_head;

    // BaseRAM port
    logic [19:0] r_base_addr;
    logic [31:0] r_base_wdata;
    logic [3:0]  r_base_be_n;
    logic        r_base_ce_n, r_base_oe_n, r_base_we_n, r_base_doe, r_fetch_pend;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base_addr  <= '0;
            r_base_wdata <= '0;
            r_base_be_n  <= '1;
            r_base_ce_n  <= 1'b1;
            r_base_oe_n  <= 1'b1;
            r_base_we_n  <= 1'b1;
            r_base_doe   <= 1'b0;
            r_fetch_pend <= 1'b0;
        end else if (w_ext_base) begin
            // data access owns BaseRAM; the fetch this cycle is not served
            r_base_addr  <= cpu_ext_addr_i[21:2];
            r_base_ce_n  <= 1'b0;
            r_base_we_n  <= !w_ext_wr;
            r_base_oe_n  <= !w_ext_rd;
            r_base_be_n  <= w_ext_wr ? ~cpu_ext_be_i : (w_ext_rd ? 4'b0000 : 4'b1111);
            r_base_doe   <= w_ext_wr;
            if (w_ext_wr)
                r_base_wdata <= cpu_ext_wdata_i;
            r_fetch_pend <= 1'b0;
        end else if (cpu_base_ce_i) begin
            r_base_addr  <= cpu_base_addr_i[21:2];
            r_base_ce_n  <= 1'b0;
            r_base_we_n  <= 1'b1;
            r_base_oe_n  <= 1'b0;
            r_base_be_n  <= 4'b0000;
            r_base_doe   <= 1'b0;
            r_fetch_pend <= 1'b1;
        end else begin
            r_base_ce_n  <= 1'b1;
            r_base_we_n  <= 1'b1;
            r_base_oe_n  <= 1'b1;
            r_base_be_n  <= 4'b1111;
            r_base_doe   <= 1'b0;
            r_fetch_pend <= 1'b0;
        end
    end

    // ExtRAM port
    logic [19:0] r_ext_addr;
    logic [31:0] r_ext_wdata;
    logic [3:0]  r_ext_be_n;
    logic        r_ext_ce_n, r_ext_oe_n, r_ext_we_n, r_ext_doe;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_ext_addr  <= '0;
            r_ext_wdata <= '0;
            r_ext_be_n  <= '1;
            r_ext_ce_n  <= 1'b1;
            r_ext_oe_n  <= 1'b1;
            r_ext_we_n  <= 1'b1;
            r_ext_doe   <= 1'b0;
        end else if (w_ext_ext) begin
            r_ext_addr  <= cpu_ext_addr_i[21:2];
            r_ext_ce_n  <= 1'b0;
            r_ext_we_n  <= !w_ext_wr;
            r_ext_oe_n  <= !w_ext_rd;
            r_ext_be_n  <= w_ext_wr ? ~cpu_ext_be_i : (w_ext_rd ? 4'b0000 : 4'b1111);
            r_ext_doe   <= w_ext_wr;
            if (w_ext_wr)
                r_ext_wdata <= cpu_ext_wdata_i;
        end else begin
            r_ext_ce_n  <= 1'b1;
            r_ext_we_n  <= 1'b1;
            r_ext_oe_n  <= 1'b1;
            r_ext_be_n  <= 4'b1111;
            r_ext_doe   <= 1'b0;
        end
    end

    // Read source tracking and UART register snapshot
    src_t        r_rd_src;
    logic [31:0] r_uart_rdata;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_src     <= SRC_NONE;
            r_uart_rdata <= '0;
        end else begin
            if (!w_ext_rd)
                r_rd_src <= SRC_NONE;
            else if (w_ext_base)
                r_rd_src <= SRC_BASE;
            else if (w_ext_ext)
                r_rd_src <= SRC_EXT;
            else if (w_uart_dat || w_uart_sta)
                r_rd_src <= SRC_UART;
            else
                r_rd_src <= SRC_ZERO;
            r_uart_rdata <= w_uart_sta ? {30'b0, w_rx_avail, w_tx_idle}
                                       : {24'b0, (w_rx_avail ? w_rx_head : 8'h00)};
        end
    end

    logic [31:0] r_base_rdata, r_ext_rdata;
    logic        r_if_valid;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_base_rdata <= '0;
            r_ext_rdata  <= '0;
            r_if_valid   <= 1'b0;
        end else begin
            r_if_valid <= r_fetch_pend;
            if (r_fetch_pend)
                r_base_rdata <= base_ram_rdata_i;
            case (r_rd_src)
                SRC_BASE: r_ext_rdata <= base_ram_rdata_i;
                SRC_EXT:  r_ext_rdata <= ext_ram_rdata_i;
                SRC_UART: r_ext_rdata <= r_uart_rdata;
                SRC_ZERO: r_ext_rdata <= '0;
                default:  r_ext_rdata <= r_ext_rdata;
            endcase
        end
    end

    // UART transmitter
    tx_state_t      r_tx_state;
    logic [CW-1:0]  r_tx_cnt;
    logic [2:0]     r_tx_bit;
    logic [7:0]     r_tx_shift;
    logic           r_txd;

    assign w_tx_idle = (r_tx_state == TX_IDLE);
    assign w_tx_load = w_ext_wr && w_uart_dat && w_tx_idle;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_tx_state <= TX_IDLE;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_tx_shift <= '0;
            r_txd      <= 1'b1;
        end else begin
            case (r_tx_state)
                TX_IDLE: begin
                    if (w_tx_load) begin
                        r_tx_shift <= cpu_ext_wdata_i[7:0];
                        r_tx_cnt   <= '0;
                        r_tx_bit   <= '0;
                        r_txd      <= 1'b0;
                        r_tx_state <= TX_START;
                    end
                end
                TX_START: begin
                    if (r_tx_cnt == DIV_M1) begin
                        r_tx_cnt   <= '0;
                        r_txd      <= r_tx_shift[0];
                        r_tx_state <= TX_DATA;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_DATA: begin
                    if (r_tx_cnt == DIV_M1) begin
                        r_tx_cnt <= '0;
                        if (r_tx_bit == 3'd7) begin
                            r_txd      <= 1'b1;
                            r_tx_state <= TX_STOP;
                        end else begin
                            r_tx_bit   <= r_tx_bit + 1'b1;
                            r_tx_shift <= {1'b0, r_tx_shift[7:1]};
                            r_txd      <= r_tx_shift[1];
                        end
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                TX_STOP: begin
                    if (r_tx_cnt == DIV_M1) begin
                        r_tx_cnt   <= '0;
                        r_tx_state <= TX_IDLE;
                    end else begin
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                    end
                end
                default: r_tx_state <= TX_IDLE;
            endcase
        end
    end

    // UART receiver: r_rx_s3 is the previous synchronized level for edge detection
    logic r_rx_s1, r_rx_s2, r_rx_s3;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_s1 <= 1'b1;
            r_rx_s2 <= 1'b1;
            r_rx_s3 <= 1'b1;
        end else begin
            r_rx_s1 <= uart_rxd_i;
            r_rx_s2 <= r_rx_s1;
            r_rx_s3 <= r_rx_s2;
        end
    end

    rx_state_t      r_rx_state;
    logic [CW-1:0]  r_rx_cnt;
    logic [2:0]     r_rx_bit;
    logic [7:0]     r_rx_shift;
    logic [7:0]     r_rx_byte;
    logic           r_rx_push;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rx_state <= RX_IDLE;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_rx_byte  <= '0;
            r_rx_push  <= 1'b0;
        end else begin
            r_rx_push <= 1'b0;
            case (r_rx_state)
                RX_IDLE: begin
                    if (r_rx_s3 && !r_rx_s2) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_START;
                    end
                end
                RX_START: begin
                    if (r_rx_cnt == HALF_M1) begin
                        r_rx_cnt   <= '0;
                        r_rx_bit   <= '0;
                        r_rx_state <= r_rx_s2 ? RX_IDLE : RX_DATA;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_DATA: begin
                    if (r_rx_cnt == DIV_M1) begin
                        r_rx_cnt   <= '0;
                        r_rx_shift <= {r_rx_s2, r_rx_shift[7:1]};
                        if (r_rx_bit == 3'd7)
                            r_rx_state <= RX_STOP;
                        else
                            r_rx_bit <= r_rx_bit + 1'b1;
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                RX_STOP: begin
                    if (r_rx_cnt == DIV_M1) begin
                        r_rx_cnt   <= '0;
                        r_rx_state <= RX_IDLE;
                        if (r_rx_s2) begin
                            r_rx_push <= 1'b1;
                            r_rx_byte <= r_rx_shift;
                        end
                    end else begin
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                    end
                end
                default: r_rx_state <= RX_IDLE;
            endcase
        end
    end

    assign w_rx_pop = w_ext_rd && w_uart_dat && w_rx_avail;

`ifdef UART_RX_FIFO_EN
    logic [7:0] r_fifo [4];
    logic [1:0] r_wr_ptr, r_rd_ptr;
    logic [2:0] r_count;

    // a pop in the same cycle frees the slot the push needs
    assign w_push_ok  = r_rx_push && ((r_count != 3'd4) || w_rx_pop);
    assign w_rx_avail = (r_count != 3'd0);
    assign w_rx_head  = r_fifo[r_rd_ptr];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < 4; i++)
                r_fifo[i] <= '0;
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push_ok) begin
                r_fifo[r_wr_ptr] <= r_rx_byte;
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_rx_pop)
                r_rd_ptr <= r_rd_ptr + 1'b1;
            r_count <= r_count + {2'b0, w_push_ok} - {2'b0, w_rx_pop};
        end
    end
`else
    logic [7:0] r_hold;
    logic       r_hold_full;

    assign w_push_ok  = r_rx_push && (!r_hold_full || w_rx_pop);
    assign w_rx_avail = r_hold_full;
    assign w_rx_head  = r_hold;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_hold      <= '0;
            r_hold_full <= 1'b0;
        end else begin
            if (w_push_ok)
                r_hold <= r_rx_byte;
            r_hold_full <= w_push_ok || (r_hold_full && !w_rx_pop);
        end
    end
`endif

    assign cpu_base_rdata_o   = r_base_rdata;
    assign cpu_ext_rdata_o    = r_ext_rdata;
    assign to_if_valid_o      = r_if_valid;
    assign base_ram_addr_o    = r_base_addr;
    assign base_ram_wdata_o   = r_base_wdata;
    assign base_ram_be_n_o    = r_base_be_n;
    assign base_ram_ce_n_o    = r_base_ce_n;
    assign base_ram_oe_n_o    = r_base_oe_n;
    assign base_ram_we_n_o    = r_base_we_n;
    assign base_ram_data_oe_o = r_base_doe;
    assign ext_ram_addr_o     = r_ext_addr;
    assign ext_ram_wdata_o    = r_ext_wdata;
    assign ext_ram_be_n_o     = r_ext_be_n;
    assign ext_ram_ce_n_o     = r_ext_ce_n;
    assign ext_ram_oe_n_o     = r_ext_oe_n;
    assign ext_ram_we_n_o     = r_ext_we_n;
    assign ext_ram_data_oe_o  = r_ext_doe;
    assign uart_txd_o         = r_txd;

endmodule

// File: tb/tb_mem_uart_bridge.sv
// Self-checking bench for mem_uart_bridge: cycle model compared every cycle plus literal checks.
module tb_mem_uart_bridge;

    localparam int unsigned DIV = 4;
`ifdef UART_RX_FIFO_EN
    localparam int unsigned RXCAP = 4;
`else
    localparam int unsigned RXCAP = 1;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [31:0] cpu_base_addr_i = '0;
    logic        cpu_base_ce_i = 1'b0;
    logic [31:0] cpu_base_rdata_o;
    logic [31:0] cpu_ext_addr_i = '0;
    logic [31:0] cpu_ext_wdata_i = '0;
    logic [3:0]  cpu_ext_be_i = '0;
    logic        cpu_ext_ce_i = 1'b0, cpu_ext_oe_i = 1'b0, cpu_ext_we_i = 1'b0;
    logic [31:0] cpu_ext_rdata_o;
    logic        to_if_valid_o;
    logic [19:0] base_ram_addr_o, ext_ram_addr_o;
    logic [31:0] base_ram_wdata_o, ext_ram_wdata_o;
    logic [31:0] base_ram_rdata_i = '0, ext_ram_rdata_i = '0;
    logic [3:0]  base_ram_be_n_o, ext_ram_be_n_o;
    logic        base_ram_ce_n_o, base_ram_oe_n_o, base_ram_we_n_o, base_ram_data_oe_o;
    logic        ext_ram_ce_n_o, ext_ram_oe_n_o, ext_ram_we_n_o, ext_ram_data_oe_o;
    logic        uart_txd_o;
    logic        uart_rxd_i = 1'b1;

    mem_uart_bridge #(.CLK_FREQ(40), .BAUD(10)) dut (
        .clk(clk), .rst(rst),
        .cpu_base_addr_i(cpu_base_addr_i), .cpu_base_ce_i(cpu_base_ce_i),
        .cpu_base_rdata_o(cpu_base_rdata_o),
        .cpu_ext_addr_i(cpu_ext_addr_i), .cpu_ext_wdata_i(cpu_ext_wdata_i),
        .cpu_ext_be_i(cpu_ext_be_i), .cpu_ext_ce_i(cpu_ext_ce_i),
        .cpu_ext_oe_i(cpu_ext_oe_i), .cpu_ext_we_i(cpu_ext_we_i),
        .cpu_ext_rdata_o(cpu_ext_rdata_o), .to_if_valid_o(to_if_valid_o),
        .base_ram_addr_o(base_ram_addr_o), .base_ram_wdata_o(base_ram_wdata_o),
        .base_ram_rdata_i(base_ram_rdata_i), .base_ram_be_n_o(base_ram_be_n_o),
        .base_ram_ce_n_o(base_ram_ce_n_o), .base_ram_oe_n_o(base_ram_oe_n_o),
        .base_ram_we_n_o(base_ram_we_n_o), .base_ram_data_oe_o(base_ram_data_oe_o),
        .ext_ram_addr_o(ext_ram_addr_o), .ext_ram_wdata_o(ext_ram_wdata_o),
        .ext_ram_rdata_i(ext_ram_rdata_i), .ext_ram_be_n_o(ext_ram_be_n_o),
        .ext_ram_ce_n_o(ext_ram_ce_n_o), .ext_ram_oe_n_o(ext_ram_oe_n_o),
        .ext_ram_we_n_o(ext_ram_we_n_o), .ext_ram_data_oe_o(ext_ram_data_oe_o),
        .uart_txd_o(uart_txd_o), .uart_rxd_i(uart_rxd_i)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    endtask

    // ---------------- behavioural model ----------------
    logic [19:0] e_baddr, e_xaddr;
    logic [31:0] e_bwdata, e_xwdata;
    logic [7:0]  e_bstb, e_xstb;          // {ce_n, oe_n, we_n, be_n[3:0], data_oe}
    logic [31:0] e_brd, e_xrd, m_val;
    bit          e_valid, e_xv, m_fetch;
    int          m_src;                   // 0 none, 1 BaseRAM, 2 ExtRAM, 3 register value
    bit          m_tx_busy;
    int unsigned m_tx_t;
    logic [9:0]  m_frame;
    logic [7:0]  m_q[$];

    function automatic logic [7:0] stb(input bit acc, input bit rd, input bit wr, input logic [3:0] be);
        if (!acc) return 8'b1111_1110;
        if (wr)   return {1'b0, 1'b1, 1'b0, ~be, 1'b1};
        if (rd)   return {1'b0, 1'b0, 1'b1, 4'b0000, 1'b0};
        return 8'b0111_1110;
    endfunction

    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            e_baddr = '0; e_xaddr = '0; e_bwdata = '0; e_xwdata = '0;
            e_bstb = 8'b1111_1110; e_xstb = 8'b1111_1110;
            e_brd = '0; e_xrd = '0; e_valid = 0; e_xv = 0;
            m_fetch = 0; m_src = 0; m_val = '0;
            m_tx_busy = 0; m_tx_t = 0; m_frame = '1;
            m_q.delete();
        end else begin
            bit in_base, in_ext, rd, wr, busy0;
            logic [31:0] a;
            // results of last cycle's requests
            e_valid = m_fetch;
            if (m_fetch) e_brd = base_ram_rdata_i;
            e_xv = (m_src != 0);
            if (m_src == 1) e_xrd = base_ram_rdata_i;
            if (m_src == 2) e_xrd = ext_ram_rdata_i;
            if (m_src == 3) e_xrd = m_val;
            // this cycle's requests
            a = cpu_ext_addr_i;
            in_base = cpu_ext_ce_i && a >= 32'h8000_0000 && a <= 32'h803F_FFFF;
            in_ext  = cpu_ext_ce_i && a >= 32'h8040_0000 && a <= 32'h807F_FFFF;
            rd = cpu_ext_ce_i && cpu_ext_oe_i && !cpu_ext_we_i;
            wr = cpu_ext_ce_i && cpu_ext_we_i;
            busy0 = m_tx_busy;
            if (in_base) begin
                e_baddr = 20'((a - 32'h8000_0000) / 4);
                e_bstb = stb(1, rd, wr, cpu_ext_be_i);
                if (wr) e_bwdata = cpu_ext_wdata_i;
                m_fetch = 0;
            end else if (cpu_base_ce_i) begin
                e_baddr = 20'((cpu_base_addr_i % 32'h0040_0000) / 4);
                e_bstb = stb(1, 1, 0, 4'h0);
                m_fetch = 1;
            end else begin
                e_bstb = stb(0, 0, 0, 4'h0);
                m_fetch = 0;
            end
            if (in_ext) begin
                e_xaddr = 20'((a - 32'h8040_0000) / 4);
                e_xstb = stb(1, rd, wr, cpu_ext_be_i);
                if (wr) e_xwdata = cpu_ext_wdata_i;
            end else begin
                e_xstb = stb(0, 0, 0, 4'h0);
            end
            m_src = !rd ? 0 : in_base ? 1 : in_ext ? 2 : 3;
            m_val = '0;
            if (rd && a == 32'hBFD0_03FC)
                m_val = {30'b0, m_q.size() != 0, !busy0};
            if (rd && a == 32'hBFD0_03F8 && m_q.size() != 0)
                m_val = {24'b0, m_q.pop_front()};
            if (m_tx_busy) begin
                m_tx_t++;
                if (m_tx_t == 10 * DIV) m_tx_busy = 0;
            end
            if (wr && a == 32'hBFD0_03F8 && !busy0) begin
                m_tx_busy = 1;
                m_tx_t = 0;
                m_frame = {1'b1, cpu_ext_wdata_i[7:0], 1'b0};
            end
        end
    end

    always @(negedge clk) begin
        logic exp_txd;
        exp_txd = m_tx_busy ? m_frame[m_tx_t / DIV] : 1'b1;
        chk("base_strobes", {24'b0, base_ram_ce_n_o, base_ram_oe_n_o, base_ram_we_n_o,
                             base_ram_be_n_o, base_ram_data_oe_o}, {24'b0, e_bstb});
        chk("ext_strobes", {24'b0, ext_ram_ce_n_o, ext_ram_oe_n_o, ext_ram_we_n_o,
                            ext_ram_be_n_o, ext_ram_data_oe_o}, {24'b0, e_xstb});
        chk("base_addr", {12'b0, base_ram_addr_o}, {12'b0, e_baddr});
        chk("ext_addr", {12'b0, ext_ram_addr_o}, {12'b0, e_xaddr});
        chk("base_wdata", base_ram_wdata_o, e_bwdata);
        chk("ext_wdata", ext_ram_wdata_o, e_xwdata);
        chk("if_valid", {31'b0, to_if_valid_o}, {31'b0, e_valid});
        chk("txd", {31'b0, uart_txd_o}, {31'b0, exp_txd});
        if (e_valid) chk("fetch_rdata", cpu_base_rdata_o, e_brd);
        if (e_xv) chk("ext_rdata", cpu_ext_rdata_o, e_xrd);
    end

    // ---------------- stimulus ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic ext_read(input logic [31:0] a, output logic [31:0] d);
        cpu_ext_addr_i = a; cpu_ext_ce_i = 1; cpu_ext_oe_i = 1; cpu_ext_we_i = 0;
        step();
        cpu_ext_ce_i = 0; cpu_ext_oe_i = 0;
        step();
        d = cpu_ext_rdata_o;
    endtask

    task automatic ext_write(input logic [31:0] a, input logic [31:0] w, input logic [3:0] be);
        cpu_ext_addr_i = a; cpu_ext_wdata_i = w; cpu_ext_be_i = be;
        cpu_ext_ce_i = 1; cpu_ext_we_i = 1; cpu_ext_oe_i = 0;
        step();
        cpu_ext_ce_i = 0; cpu_ext_we_i = 0;
    endtask

    task automatic send_frame(input logic [7:0] b, input logic stop_bit);
        uart_rxd_i = 0;
        repeat (DIV) step();
        for (int i = 0; i < 8; i++) begin
            uart_rxd_i = b[i];
            repeat (DIV) step();
        end
        uart_rxd_i = stop_bit;
        repeat (DIV) step();
        uart_rxd_i = 1;
        repeat (3 * DIV) step();
        if (stop_bit && m_q.size() < RXCAP) m_q.push_back(b);
    endtask

    localparam logic [9:0] FRAME55 = 10'b1_0101_0101_0;

    initial begin
        logic [31:0] d;
        logic [9:0]  fr;
        fr = FRAME55;
        #2 rst = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_txd", {31'b0, uart_txd_o}, 32'd1);
        chk("rst_base_ce_n", {31'b0, base_ram_ce_n_o}, 32'd1);
        chk("rst_ext_we_n", {31'b0, ext_ram_we_n_o}, 32'd1);
        chk("rst_valid", {31'b0, to_if_valid_o}, 32'd0);
        rst = 1;
        step();
        ext_read(32'hBFD0_03FC, d);
        chk("rst_status", d, 32'h1);

        // fetch
        cpu_base_addr_i = 32'h8000_0010; cpu_base_ce_i = 1; base_ram_rdata_i = 32'h1234_5678;
        step();
        chk("fetch_addr", {12'b0, base_ram_addr_o}, 32'h4);
        cpu_base_ce_i = 0;
        step();
        chk("fetch_data", cpu_base_rdata_o, 32'h1234_5678);
        chk("fetch_valid", {31'b0, to_if_valid_o}, 32'd1);

        // ExtRAM store
        ext_write(32'h8040_0008, 32'hDEAD_BEEF, 4'b0011);
        chk("st_we_n", {31'b0, ext_ram_we_n_o}, 32'd0);
        chk("st_be_n", {28'b0, ext_ram_be_n_o}, 32'hC);
        chk("st_addr", {12'b0, ext_ram_addr_o}, 32'h2);
        step();
        chk("st_we_n_end", {31'b0, ext_ram_we_n_o}, 32'd1);

        // conflict: load from BaseRAM with concurrent fetch
        base_ram_rdata_i = 32'hCAFE_F00D;
        cpu_base_addr_i = 32'h8000_0020; cpu_base_ce_i = 1;
        cpu_ext_addr_i = 32'h8000_0100; cpu_ext_ce_i = 1; cpu_ext_oe_i = 1;
        step();
        chk("cf_addr", {12'b0, base_ram_addr_o}, 32'h40);
        cpu_base_ce_i = 0; cpu_ext_ce_i = 0; cpu_ext_oe_i = 0;
        step();
        chk("cf_valid", {31'b0, to_if_valid_o}, 32'd0);
        chk("cf_rdata", cpu_ext_rdata_o, 32'hCAFE_F00D);

        // ExtRAM load, range boundaries, unmapped accesses
        ext_ram_rdata_i = 32'h0BAD_C0DE;
        ext_read(32'h8040_0010, d);
        chk("ext_load", d, 32'h0BAD_C0DE);
        ext_read(32'h803F_FFFC, d);
        ext_read(32'h8040_0000, d);
        ext_read(32'h1234_0000, d);
        chk("unmapped_rd", d, 32'h0);
        ext_write(32'h1234_0000, 32'hFFFF_FFFF, 4'hF);
        ext_write(32'hBFD0_03FC, 32'hFFFF_FFFF, 4'hF);
        step();

        // UART transmit 0x55, a dropped write while busy, status read while busy
        ext_write(32'hBFD0_03F8, 32'h55, 4'h1);
        for (int c = 0; c < 40; c++) begin
            if (c % 4 == 0)
                chk("tx_bit", {31'b0, uart_txd_o}, {31'b0, fr[c / 4]});
            if (c == 9) begin
                cpu_ext_addr_i = 32'hBFD0_03F8; cpu_ext_wdata_i = 32'hFF;
                cpu_ext_ce_i = 1; cpu_ext_we_i = 1;
            end
            if (c == 10) begin cpu_ext_ce_i = 0; cpu_ext_we_i = 0; end
            if (c == 20) begin
                cpu_ext_addr_i = 32'hBFD0_03FC; cpu_ext_ce_i = 1; cpu_ext_oe_i = 1;
            end
            if (c == 21) begin cpu_ext_ce_i = 0; cpu_ext_oe_i = 0; end
            if (c == 22) chk("tx_busy_status", cpu_ext_rdata_o, 32'h0);
            step();
        end
        ext_read(32'hBFD0_03FC, d);
        chk("tx_done_status", d, 32'h1);

        // UART receive
        send_frame(8'hA3, 1'b1);
        ext_read(32'hBFD0_03FC, d);
        chk("rx_status", d, 32'h3);
        ext_read(32'hBFD0_03F8, d);
        chk("rx_data", d, 32'hA3);
        ext_read(32'hBFD0_03FC, d);
        chk("rx_status_empty", d, 32'h1);
        ext_read(32'hBFD0_03F8, d);
        chk("rx_empty_read", d, 32'h0);
        send_frame(8'h5A, 1'b0);
        ext_read(32'hBFD0_03FC, d);
        chk("rx_bad_stop", d, 32'h1);

        for (int k = 1; k <= 5; k++) send_frame(8'(k * 'h11), 1'b1);
        ext_read(32'hBFD0_03F8, d);
        chk("rx_first", d, 32'h11);
`ifdef UART_RX_FIFO_EN
        ext_read(32'hBFD0_03F8, d); chk("rx_second", d, 32'h22);
        ext_read(32'hBFD0_03F8, d); chk("rx_third", d, 32'h33);
        ext_read(32'hBFD0_03F8, d); chk("rx_fourth", d, 32'h44);
`endif
        ext_read(32'hBFD0_03F8, d);
        chk("rx_overflow_dropped", d, 32'h0);

        // reset mid-frame on both TX and RX
        ext_write(32'hBFD0_03F8, 32'h00, 4'h1);
        uart_rxd_i = 0;
        repeat (10) step();
        #2 rst = 0; uart_rxd_i = 1;
        #1 chk("rst_mid_txd", {31'b0, uart_txd_o}, 32'd1);
        repeat (3) @(posedge clk);
        #1 rst = 1;
        repeat (60) step();
        ext_read(32'hBFD0_03FC, d);
        chk("rst_mid_status", d, 32'h1);
        step();

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
